frame_buffer_scheduler: RTL and testbench

//  Triple-buffer scheduler for the DDR frame store between the camera capture path and the HDMI reader.

---
 rtl/fb_pkg.sv | 21 ++
 rtl/frame_pixel_counter.sv | 43 ++++
 rtl/frame_buffer_scheduler.sv | 140 ++++++++++++++
 tb/tb_frame_buffer_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared frame-store geometry, buffer index type and default addresses.
package fb_pkg;

    localparam int unsigned FRAME_W         = 320;
    localparam int unsigned FRAME_H         = 240;
    localparam int unsigned BYTES_PER_PIXEL = 2;

    localparam int unsigned FRAME_PIXELS = FRAME_W * FRAME_H;
    localparam logic [31:0] FRAME_STRIDE = 32'(FRAME_PIXELS * BYTES_PER_PIXEL);
    localparam logic [31:0] BASE_ADDR    = 32'h1000_0000;

    // Counter must hold FRAME_PIXELS+1 so a long frame is distinguishable from an exact one.
    localparam int unsigned CNT_W = $clog2(FRAME_PIXELS + 2);

    typedef logic [1:0] buf_idx_t;

    localparam buf_idx_t RST_W_IDX = 2'd0;
    localparam buf_idx_t RST_P_IDX = 2'd1;
    localparam buf_idx_t RST_R_IDX = 2'd2;

endpackage

// File: rtl/frame_pixel_counter.sv
// Saturating per-frame pixel counter with an exact-length match flag.
// count_ok looks at the count including a pixel arriving this cycle,
// so the pixel coincident with the frame boundary belongs to the closing frame.
module frame_pixel_counter #(
    parameter int unsigned FRAME_PIXELS = fb_pkg::FRAME_PIXELS,
    parameter int unsigned CNT_W        = fb_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic inc,
    input  logic clear,
    output logic count_ok
);

    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(FRAME_PIXELS + 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(FRAME_PIXELS);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_inc;

    // Count including the current pixel, held at the saturation value.
    always_comb begin
        count_inc = count_q;
        if (en && inc && (count_q != CNT_SAT)) begin
            count_inc = count_q + CNT_W'(1);
        end
    end

    assign count_ok = (count_inc == CNT_TARGET);

    // Clear on frame boundary, otherwise accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_inc;
        end
    end

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer scheduler: writer, pending and reader buffer roles rotate so the
// reader always gets the newest complete frame and never a torn one.
module frame_buffer_scheduler #(
    parameter logic [31:0] BASE_ADDR    = fb_pkg::BASE_ADDR,
    parameter logic [31:0] FRAME_STRIDE = fb_pkg::FRAME_STRIDE,
    parameter int unsigned FRAME_PIXELS = fb_pkg::FRAME_PIXELS,
    parameter int unsigned CNT_W        = fb_pkg::CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        frame_done,
    input  logic        pixel_valid,
    input  logic        rd_frame_start,
    output logic [31:0] wr_base_addr,
    output logic [31:0] rd_base_addr,
    output logic [1:0]  wr_buf_idx,
    output logic [1:0]  rd_buf_idx,
    output logic        rd_valid,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_dropped
);

    import fb_pkg::*;

    localparam logic [31:0] ADDR0 = BASE_ADDR;
    localparam logic [31:0] ADDR1 = BASE_ADDR + FRAME_STRIDE;
    localparam logic [31:0] ADDR2 = ADDR1 + FRAME_STRIDE;

    // Constant address select; index 3 never occurs.
    function automatic logic [31:0] addr_of(input buf_idx_t idx);
        case (idx)
            2'd0:    addr_of = ADDR0;
            2'd1:    addr_of = ADDR1;
            default: addr_of = ADDR2;
        endcase
    endfunction

    logic        fd_q;
    logic        fb_c;
    logic        rd_req_c;
    logic        count_ok_c;

    buf_idx_t    w_q, p_q, r_q;
    buf_idx_t    w_n, p_n, r_n;
    logic        pend_q, pend_n;
    logic        rd_valid_q, rd_valid_n;
    logic [15:0] ok_q, ok_n;
    logic [15:0] drop_q, drop_n;
    logic [31:0] wr_addr_q, wr_addr_n;
    logic [31:0] rd_addr_q, rd_addr_n;

    assign fb_c     = enable & frame_done & ~fd_q;
    assign rd_req_c = enable & rd_frame_start;

    frame_pixel_counter #(
        .FRAME_PIXELS (FRAME_PIXELS),
        .CNT_W        (CNT_W)
    ) u_pixel_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (enable),
        .inc      (pixel_valid),
        .clear    (fb_c),
        .count_ok (count_ok_c)
    );

    // Frame-sync edge detector; samples regardless of enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            fd_q <= 1'b0;
        end else begin
            fd_q <= frame_done;
        end
    end

    // Role rotation: writer commit first, then reader pickup of whatever is pending.
    always_comb begin
        w_n        = w_q;
        p_n        = p_q;
        r_n        = r_q;
        pend_n     = pend_q;
        rd_valid_n = rd_valid_q;
        ok_n       = ok_q;
        drop_n     = drop_q;

        if (fb_c && count_ok_c) begin
            w_n    = p_q;
            p_n    = w_q;
            pend_n = 1'b1;
            ok_n   = ok_q + 16'd1;
        end else if (fb_c) begin
            drop_n = drop_q + 16'd1;
        end

        if (rd_req_c && pend_n) begin
            r_n        = p_n;
            p_n        = r_q;
            pend_n     = 1'b0;
            rd_valid_n = 1'b1;
        end

        wr_addr_n = addr_of(w_n);
        rd_addr_n = addr_of(r_n);
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_q        <= RST_W_IDX;
            p_q        <= RST_P_IDX;
            r_q        <= RST_R_IDX;
            pend_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            ok_q       <= '0;
            drop_q     <= '0;
            wr_addr_q  <= ADDR0;
            rd_addr_q  <= ADDR2;
        end else begin
            w_q        <= w_n;
            p_q        <= p_n;
            r_q        <= r_n;
            pend_q     <= pend_n;
            rd_valid_q <= rd_valid_n;
            ok_q       <= ok_n;
            drop_q     <= drop_n;
            wr_addr_q  <= wr_addr_n;
            rd_addr_q  <= rd_addr_n;
        end
    end

    assign wr_buf_idx     = w_q;
    assign rd_buf_idx     = r_q;
    assign rd_valid       = rd_valid_q;
    assign frames_ok      = ok_q;
    assign frames_dropped = drop_q;
    assign wr_base_addr   = wr_addr_q;
    assign rd_base_addr   = rd_addr_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Bench for frame_buffer_scheduler: a full-size instance and a small-frame
// instance share stimulus; both are compared every cycle to a role-rotation model.
module tb_frame_buffer_scheduler;

    localparam int unsigned SMALL_PIX = 64;

    logic clk = 1'b0;
    logic rst, enable, frame_done, pixel_valid, rd_frame_start;

    logic [31:0] f_wa, f_ra, s_wa, s_ra;
    logic [1:0]  f_wi, f_ri, s_wi, s_ri;
    logic        f_rv, s_rv;
    logic [15:0] f_ok, f_dr, s_ok, s_dr;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state per instance: 0 = full size, 1 = small frame.
    int m_n[2] = '{76800, SMALL_PIX};
    int m_w[2], m_p[2], m_r[2], m_pend[2], m_rdv[2], m_cnt[2], m_ok[2], m_drop[2], m_fdq[2];

    always #5 clk = ~clk;

    frame_buffer_scheduler dut_full (
        .clk(clk), .rst(rst), .enable(enable), .frame_done(frame_done),
        .pixel_valid(pixel_valid), .rd_frame_start(rd_frame_start),
        .wr_base_addr(f_wa), .rd_base_addr(f_ra), .wr_buf_idx(f_wi), .rd_buf_idx(f_ri),
        .rd_valid(f_rv), .frames_ok(f_ok), .frames_dropped(f_dr)
    );

    frame_buffer_scheduler #(.FRAME_PIXELS(SMALL_PIX), .CNT_W(7)) dut_small (
        .clk(clk), .rst(rst), .enable(enable), .frame_done(frame_done),
        .pixel_valid(pixel_valid), .rd_frame_start(rd_frame_start),
        .wr_base_addr(s_wa), .rd_base_addr(s_ra), .wr_buf_idx(s_wi), .rd_buf_idx(s_ri),
        .rd_valid(s_rv), .frames_ok(s_ok), .frames_dropped(s_dr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] exp_addr(input int idx);
        return 32'h1000_0000 + 32'(idx) * 32'h0002_5800;
    endfunction

    // Reference behaviour: roles W/P/R as integers, rotated by swaps.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_w[k] = 0; m_p[k] = 1; m_r[k] = 2; m_pend[k] = 0; m_rdv[k] = 0;
                m_cnt[k] = 0; m_ok[k] = 0; m_drop[k] = 0; m_fdq[k] = 0;
            end else begin
                int t;
                bit fbv;
                fbv = enable && frame_done && (m_fdq[k] == 0);
                m_fdq[k] = int'(frame_done);
                if (enable && pixel_valid && m_cnt[k] < m_n[k] + 1) m_cnt[k]++;
                if (fbv) begin
                    if (m_cnt[k] == m_n[k]) begin
                        t = m_w[k]; m_w[k] = m_p[k]; m_p[k] = t;
                        m_pend[k] = 1;
                        m_ok[k] = (m_ok[k] + 1) % 65536;
                    end else begin
                        m_drop[k] = (m_drop[k] + 1) % 65536;
                    end
                    m_cnt[k] = 0;
                end
                if (enable && rd_frame_start && m_pend[k] != 0) begin
                    t = m_r[k]; m_r[k] = m_p[k]; m_p[k] = t;
                    m_pend[k] = 0;
                    m_rdv[k] = 1;
                end
            end
        end
    end

    task automatic compare_one(input int k, input string pfx,
                               input logic [31:0] wa, input logic [31:0] ra,
                               input logic [1:0] wi, input logic [1:0] ri, input logic rv,
                               input logic [15:0] ok, input logic [15:0] dr);
        check({pfx, ".wr_idx"},   32'(wi), 32'(m_w[k]));
        check({pfx, ".rd_idx"},   32'(ri), 32'(m_r[k]));
        check({pfx, ".wr_addr"},  wa, exp_addr(m_w[k]));
        check({pfx, ".rd_addr"},  ra, exp_addr(m_r[k]));
        check({pfx, ".rd_valid"}, 32'(rv), 32'(m_rdv[k]));
        check({pfx, ".ok"},       32'(ok), 32'(m_ok[k]));
        check({pfx, ".dropped"},  32'(dr), 32'(m_drop[k]));
        check({pfx, ".distinct"}, 32'({wi != ri, wi < 2'd3, ri < 2'd3}), 32'd7);
    endtask

    task automatic tick();
        @(negedge clk);
        compare_one(0, "full",  f_wa, f_ra, f_wi, f_ri, f_rv, f_ok, f_dr);
        compare_one(1, "small", s_wa, s_ra, s_wi, s_ri, s_rv, s_ok, s_dr);
    endtask

    task automatic drive(input logic en, input logic fd, input logic pv, input logic rs);
        enable = en; frame_done = fd; pixel_valid = pv; rd_frame_start = rs;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic frame(input int npix);
        for (int i = 0; i < npix; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; frame_done = 1'b0; pixel_valid = 1'b0; rd_frame_start = 1'b0;

        // Reset state
        do_reset();
        check("rst.wr_idx",  32'(s_wi), 32'd0);
        check("rst.rd_idx",  32'(s_ri), 32'd2);
        check("rst.rd_valid", 32'(s_rv), 32'd0);
        check("rst.wr_addr", f_wa, 32'h1000_0000);
        check("rst.rd_addr", f_ra, 32'h1004_B000);

        // Partial first frame is dropped
        frame(10);
        check("partial.dropped", 32'(s_dr), 32'd1);
        check("partial.wr_idx",  32'(s_wi), 32'd0);
        check("partial.ok",      32'(s_ok), 32'd0);

        // Complete frame, then reader picks it up
        frame(SMALL_PIX);
        check("normal.wr_idx", 32'(s_wi), 32'd1);
        check("normal.ok",     32'(s_ok), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        check("normal.rd_idx",   32'(s_ri), 32'd0);
        check("normal.rd_valid", 32'(s_rv), 32'd1);
        check("normal.rd_addr",  s_ra, 32'h1000_0000);

        // Writer faster than reader: newest of two frames wins (W=1,P=2,R=0 start)
        frame(SMALL_PIX);
        frame(SMALL_PIX);
        check("fast.wr_idx", 32'(s_wi), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        check("fast.rd_idx", 32'(s_ri), 32'd2);

        // Same-cycle commit and reader request from W=1,P=0,R=2; last pixel in the fb cycle
        for (int i = 0; i < SMALL_PIX - 1; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("same.wr_idx", 32'(s_wi), 32'd0);
        check("same.rd_idx", 32'(s_ri), 32'd1);
        check("same.ok",     32'(s_ok), 32'd4);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        check("same.no_pend_rd_idx", 32'(s_ri), 32'd1);

        // Long frame dropped; disabled boundary ignored; mid-frame reset
        frame(SMALL_PIX + 1);
        check("long.dropped", 32'(s_dr), 32'd2);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("gate.dropped", 32'(s_dr), 32'd2);
        check("gate.wr_idx",  32'(s_wi), 32'd0);
        check("gate.rd_idx",  32'(s_ri), 32'd1);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
        do_reset();
        check("midrst.wr_idx",  32'(s_wi), 32'd0);
        check("midrst.rd_idx",  32'(s_ri), 32'd2);
        check("midrst.dropped", 32'(s_dr), 32'd0);
        check("midrst.rd_addr", s_ra, 32'h1004_B000);

        // Randomised frames around the exact length with gating and reader pulses
        for (int f = 0; f < 40; f++) begin
            int npix, sent, pick;
            pick = int'($urandom_range(0, 6));
            case (pick)
                0: npix = SMALL_PIX - 1;
                1: npix = SMALL_PIX + 1;
                2: npix = int'($urandom_range(0, 70));
                default: npix = SMALL_PIX;
            endcase
            sent = 0;
            while (sent < npix) begin
                logic en_r, pv_r, rs_r;
                pv_r = ($urandom_range(0, 3) != 0);
                en_r = ($urandom_range(0, 29) != 0);
                rs_r = ($urandom_range(0, 19) == 0);
                drive(en_r, 1'b0, pv_r, rs_r);
                if (pv_r && en_r) sent++;
            end
            for (int c = 0; c < int'($urandom_range(1, 3)); c++)
                drive($urandom_range(0, 5) != 0, 1'b1, 1'(($urandom_range(0, 1))),
                      1'(($urandom_range(0, 1))));
            drive(1'b1, 1'b0, 1'b0, 1'(($urandom_range(0, 1))));
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        // Full-size frame: exact for the full instance, long for the small one
        do_reset();
        frame(76800);
        check("full.commit_wr_idx", 32'(f_wi), 32'd1);
        check("full.commit_ok",     32'(f_ok), 32'd1);
        check("full.small_drop",    32'(s_dr), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        check("full.rd_addr",  f_ra, 32'h1000_0000);
        check("full.rd_valid", 32'(f_rv), 32'd1);
        check("full.small_rv", 32'(s_rv), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
